// File: rtl/seq_alu_pkg.sv
// Shared opcode map and FSM state type for the registered, handshaked ALU.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_DIV = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/seq_alu_divider.sv
// Restoring divider: one quotient bit per cycle, MSB first; done_o pulses after the last bit.
module seq_alu_divider #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] quot_o
);

  logic [W-1:0]     quot_q;
  logic [W-1:0]     rem_q;
  logic [W-1:0]     dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic [W:0]       trial_w;
  logic [W:0]       diff_w;

  // Remainder stays below the divisor, so the trial fits W+1 bits and bit W of
  // the difference is the "does not fit" indicator.
  assign trial_w = {rem_q, quot_q[W-1]};
  assign diff_w  = trial_w - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        quot_q <= dividend_i;
        rem_q  <= '0;
        dvs_q  <= divisor_i;
        cnt_q  <= CNT_W'(W);
      end else if (cnt_q != '0) begin
        if (!diff_w[W]) begin
          rem_q  <= diff_w[W-1:0];
          quot_q <= {quot_q[W-2:0], 1'b1};
        end else begin
          rem_q  <= trial_w[W-1:0];
          quot_q <= {quot_q[W-2:0], 1'b0};
        end
        cnt_q  <= cnt_q - CNT_W'(1);
        done_q <= (cnt_q == CNT_W'(1));
      end
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked registered ALU with multi-cycle divider; SEQ_ALU_FLAGS_EN adds zero/carry/neg flags.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         div_by_zero,
  output logic         busy
`ifdef SEQ_ALU_FLAGS_EN
  ,
  output logic         flag_zero,
  output logic         flag_carry,
  output logic         flag_neg
`endif
);

  localparam int unsigned CNT_W = $clog2(W + 1);

  state_e         state_q;
  logic [W-1:0]   result_q;
  logic           out_valid_q;
  logic           dbz_q;
  logic           accept;
  logic           div_start;
  logic           div_done;
  logic [W-1:0]   div_quot;
  logic [W:0]     sum_w;
  logic [W:0]     diff_w;
  logic [2*W-1:0] prod_w;
  logic [W-1:0]   alu_res;
  logic           alu_carry;
  logic           load_d;
  logic [W-1:0]   res_d;
  logic           dbz_d;
  logic           carry_d;

  assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign div_start = accept && (op == OP_DIV) && (b != '0);

  seq_alu_divider #(.W(W), .CNT_W(CNT_W)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (a),
    .divisor_i  (b),
    .busy_o     (busy),
    .done_o     (div_done),
    .quot_o     (div_quot)
  );

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign prod_w = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD:  begin alu_res = sum_w[W-1:0];  alu_carry = sum_w[W];  end
      OP_SUB:  begin alu_res = diff_w[W-1:0]; alu_carry = diff_w[W]; end
      OP_DIV:  alu_res = '1;
      OP_MUL:  begin alu_res = prod_w[W-1:0]; alu_carry = |prod_w[2*W-1:W]; end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOT:  alu_res = ~a;
      default: alu_res = a ^ b;
    endcase
  end

  // One load path for both single-cycle ops (incl. div-by-zero) and divider completion.
  always_comb begin
    load_d  = 1'b0;
    res_d   = alu_res;
    dbz_d   = 1'b0;
    carry_d = alu_carry;
    if (accept && !div_start) begin
      load_d = 1'b1;
      dbz_d  = (op == OP_DIV);
    end else if ((state_q == ST_DIV) && div_done) begin
      load_d  = 1'b1;
      res_d   = div_quot;
      carry_d = 1'b0;
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic flag_zero_q;
  logic flag_carry_q;
  logic flag_neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_zero_q  <= 1'b0;
      flag_carry_q <= 1'b0;
      flag_neg_q   <= 1'b0;
    end else if (load_d) begin
      flag_zero_q  <= (res_d == '0);
      flag_carry_q <= carry_d;
      flag_neg_q   <= res_d[W-1];
    end
  end

  assign flag_zero  = flag_zero_q;
  assign flag_carry = flag_carry_q;
  assign flag_neg   = flag_neg_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
    end else begin
      if (load_d) begin
        result_q <= res_d;
        dbz_q    <= dbz_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (load_d) begin
            out_valid_q <= 1'b1;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (div_start) begin
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            out_valid_q <= 1'b1;
            state_q     <= out_ready ? ST_IDLE : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed + random bench for seq_alu (W=8) with a result scoreboard; honours SEQ_ALU_FLAGS_EN.
module tb_seq_alu;

  localparam int unsigned W     = 8;
  localparam int unsigned LIMIT = 200;

  typedef struct {
    logic [W-1:0] r;
    logic         dbz;
    logic         z;
    logic         c;
    logic         n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         busy;
`ifdef SEQ_ALU_FLAGS_EN
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_neg;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  seq_alu #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .div_by_zero (div_by_zero),
    .busy        (busy)
`ifdef SEQ_ALU_FLAGS_EN
    ,
    .flag_zero   (flag_zero),
    .flag_carry  (flag_carry),
    .flag_neg    (flag_neg)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint unsigned xl, yl, t;
    longint unsigned m;
    xl = longint'(x);
    yl = longint'(y);
    m  = (64'd1 << W) - 1;
    e.dbz = 1'b0;
    e.c   = 1'b0;
    t     = 0;
    case (o)
      3'd0: begin t = xl + yl; e.c = (t > m); end
      3'd1: begin t = xl - yl; e.c = (xl < yl); end
      3'd2: begin
        if (yl == 0) begin t = m; e.dbz = 1'b1; end
        else t = xl / yl;
      end
      3'd3: begin t = xl * yl; e.c = ((t >> W) != 0); end
      3'd4: t = xl & yl;
      3'd5: t = xl | yl;
      3'd6: t = ~xl;
      default: t = xl ^ yl;
    endcase
    e.r = W'(t & m);
    e.z = (e.r == '0);
    e.n = e.r[W-1];
    return e;
  endfunction

  // Expected results enter the scoreboard at the accepting edge.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) sb.push_back(model(op, a, b));
  end

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 64'(result), 64'(e.r));
        check("sb_dbz", 64'(div_by_zero), 64'(e.dbz));
`ifdef SEQ_ALU_FLAGS_EN
        check("sb_zero", 64'(flag_zero), 64'(e.z));
        check("sb_carry", 64'(flag_carry), 64'(e.c));
        check("sb_neg", 64'(flag_neg), 64'(e.n));
`endif
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait", 64'(n < LIMIT), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned busy_cnt;
    int unsigned first_ov;
    int unsigned ov_cnt;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef SEQ_ALU_FLAGS_EN
    check("rst_flags", 64'({flag_zero, flag_carry, flag_neg}), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    issue(3'd0, 8'd200, 8'd100);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'd44);
`ifdef SEQ_ALU_FLAGS_EN
    check("add_carry", 64'(flag_carry), 64'd1);
    check("add_zero", 64'(flag_zero), 64'd0);
`endif

    issue(3'd1, 8'd5, 8'd10);
    check("sub_result", 64'(result), 64'd251);
`ifdef SEQ_ALU_FLAGS_EN
    check("sub_borrow", 64'(flag_carry), 64'd1);
    check("sub_neg", 64'(flag_neg), 64'd1);
`endif

    // Division latency: busy 8 cycles, out_valid 9 cycles after accept
    issue(3'd2, 8'd200, 8'd7);
    busy_cnt = 0;
    first_ov = 0;
    for (int unsigned k = 0; k <= 12; k++) begin
      if (busy) busy_cnt++;
      if (out_valid && first_ov == 0) first_ov = k;
      if (k != 12) idle(1);
    end
    check("div_busy_cycles", 64'(busy_cnt), 64'd8);
    check("div_latency", 64'(first_ov), 64'd9);
    check("div_result", 64'(result), 64'd28);

    issue(3'd2, 8'd9, 8'd0);
    check("dbz_valid", 64'(out_valid), 64'd1);
    check("dbz_result", 64'(result), 64'd255);
    check("dbz_flag", 64'(div_by_zero), 64'd1);
    issue(3'd0, 8'd1, 8'd1);
    check("dbz_cleared", 64'(div_by_zero), 64'd0);
    check("dbz_next_result", 64'(result), 64'd2);

    // Backpressure on a single-cycle result
    idle(2);
    out_ready = 1'b0;
    issue(3'd3, 8'd16, 8'd17);
    for (int unsigned k = 0; k < 5; k++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_result", 64'(result), 64'd16);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      idle(1);
    end
    out_ready = 1'b1;

    // Division completing under backpressure parks in HOLD
    idle(2);
    out_ready = 1'b0;
    issue(3'd2, 8'd100, 8'd3);
    idle(12);
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_result", 64'(result), 64'd33);
    check("hold_in_ready", 64'(in_ready), 64'd0);
    check("hold_busy", 64'(busy), 64'd0);
    out_ready = 1'b1;

    // Reset during division
    idle(2);
    issue(3'd2, 8'd200, 8'd7);
    idle(3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    issue(3'd0, 8'd3, 8'd4);
    check("post_rst_add", 64'(result), 64'd7);

    // Streaming: 10 back-to-back adds
    ov_cnt = 0;
    in_valid = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      op = 3'd0;
      a = W'(i * 3);
      b = W'(i + 1);
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0 && out_valid) ov_cnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (out_valid) ov_cnt++;
    check("stream_results", 64'(ov_cnt), 64'd10);
    @(negedge clk);
    check("stream_drained", 64'(out_valid), 64'd0);

    // Random operations against the model
    for (int unsigned i = 0; i < 40; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      issue(ro, ra, rb);
    end

    idle(20);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
